// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Combinational lookup on the fetch PC, trained by the resolved C-stage branch/jump.
module branch_target_predictor #(
    parameter int  XLEN    = 32,
    parameter int  ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC_I,
    output logic            Predict,
    output logic [XLEN-1:0] Prediction,
    input  logic            UpdateValid_C,
    input  logic [XLEN-1:0] UpdatePC_C,
    input  logic            UpdateTaken_C,
    input  logic            UpdateIsJump_C,
    input  logic [XLEN-1:0] UpdateTarget_C,
    input  logic            FlushAll,
    output logic            Hit
);

    localparam int TAG_W = XLEN - IDX_W - 2;

    typedef enum logic [1:0] {
        CTR_SN = 2'b00,
        CTR_WN = 2'b01,
        CTR_WT = 2'b10,
        CTR_ST = 2'b11
    } ctr_e;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q     [ENTRIES];
    logic [XLEN-1:1]    target_q  [ENTRIES];
    logic               is_jump_q [ENTRIES];
    ctr_e               ctr_q     [ENTRIES];

    // Predictions are always halfword aligned and PCs are word indexed.
    logic unused_low_bits;
    assign unused_low_bits = ^{PC_I[1:0], UpdatePC_C[1:0], UpdateTarget_C[0]};

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;

    assign look_idx   = PC_I[IDX_W+1:2];
    assign look_tag   = PC_I[XLEN-1:IDX_W+2];
    assign Hit        = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    assign Predict    = Hit && (is_jump_q[look_idx] || ctr_q[look_idx][1]);
    assign Prediction = Hit ? {target_q[look_idx], 1'b0} : '0;

    // ---------------- training ----------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_taken;
    logic             upd_en;
    logic             alloc_we;
    logic             ctr_we;
    ctr_e             ctr_next;

    assign upd_idx   = UpdatePC_C[IDX_W+1:2];
    assign upd_tag   = UpdatePC_C[XLEN-1:IDX_W+2];
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    // A jump reported as not-taken is illegal and is trained as taken.
    assign upd_taken = UpdateTaken_C || UpdateIsJump_C;
    assign upd_en    = UpdateValid_C && !reset && !FlushAll;
    assign alloc_we  = upd_en && upd_taken;
    assign ctr_we    = upd_en && (upd_taken || upd_hit);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ctr_next = ctr_q[upd_idx];
        if (!upd_hit) begin
            ctr_next = UpdateIsJump_C ? CTR_ST : CTR_WT;
        end else if (upd_taken) begin
            if (ctr_q[upd_idx] != CTR_ST) ctr_next = ctr_e'(ctr_q[upd_idx] + 2'd1);
        end else begin
            if (ctr_q[upd_idx] != CTR_SN) ctr_next = ctr_e'(ctr_q[upd_idx] - 2'd1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || FlushAll) begin
            valid_q <= '0;
        end else if (alloc_we) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    // NOTE: entry payload is not reset; the valid bits alone gate every use of it.
    always_ff @(posedge clk) begin
        if (alloc_we) begin
            tag_q[upd_idx]     <= upd_tag;
            target_q[upd_idx]  <= UpdateTarget_C[XLEN-1:1];
            is_jump_q[upd_idx] <= UpdateIsJump_C;
        end
        if (ctr_we) begin
            ctr_q[upd_idx] <= ctr_next;
        end
    end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Direct-mapped branch target buffer with per-entry 2-bit saturating counters.
- Supplies the Predict / Prediction pair consumed by the I-stage PC update logic.
- Lookup is combinational on the fetch PC; training comes from the resolved branch/jump in the C stage.
- Sequences the PC-select datapath by deciding, every fetch cycle, whether the next PC is PC+4 or a predicted target.

Parameters:
- XLEN, 32, datapath/PC width.
- ENTRIES, 16, number of BTB entries; power of two, ≥2.
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- PC_I  input  XLEN  fetch PC being looked up.
- Predict  output  1  1 = redirect fetch to Prediction.
- Prediction  output  XLEN  predicted target, bit 0 forced to 0.
- UpdateValid_C  input  1  resolved branch/jump present in C stage this cycle.
- UpdatePC_C  input  XLEN  PC of the resolved instruction.
- UpdateTaken_C  input  1  instruction actually redirected (branch taken or any jump).
- UpdateIsJump_C  input  1  instruction is unconditional (JAL/JALR).
- UpdateTarget_C  input  XLEN  resolved target address.
- FlushAll  input  1  invalidate every entry (fence.i / context change).
- Hit  output  1  tag match on PC_I, for hazard/perf use.

Behaviour:
- Index = PC[IDX_W+1:2]; tag = PC[XLEN-1:IDX_W+2]. PC bits [1:0] are ignored.
- Entry contents:
  - valid (1)
  - tag (XLEN-IDX_W-2)
  - target (XLEN)
  - isJump (1)
  - ctr (2): 00 SN, 01 WN, 10 WT, 11 ST.
- Lookup is purely combinational, zero latency, and always reflects state before the current edge.
  - Hit = valid & tag match.
  - Predict = Hit & (isJump | ctr[1]).
  - Prediction = {target[XLEN-1:1], 1'b0} when Hit, else 0.
- Update on a clock edge with UpdateValid_C=1, indexed by UpdatePC_C:
  - Hit, taken: ctr = min(ctr+1, 11); target and isJump overwritten.
  - Hit, not taken: ctr = max(ctr-1, 00); target unchanged.
  - Miss, taken: allocate (replace any occupant). Set valid=1, new tag, target, isJump; ctr=11 if isJump else 10.
  - Miss, not taken: no change.
  - UpdateIsJump_C=1 with UpdateTaken_C=0 is illegal; treat it as taken.
- Same-cycle lookup and update to the same index: lookup returns the old entry; the new value is visible the next cycle. No bypass.
- FlushAll=1: all valid bits are 0 after the edge and any same-cycle update is dropped. Lookup in that cycle still uses the old state.
- reset=1: all valid bits are 0 after the edge and updates are ignored. Tags, targets and counters need not be reset.
  - Outputs after reset: Hit=0, Predict=0, Prediction=0.
  - Reset asserted mid-training discards that cycle's update.
- Counter saturation: 11 stays 11 on taken; 00 stays 00 on not-taken. No wrap.
- Aliasing: a different tag at the same index on a taken update evicts the old entry. Not-taken never evicts.

Test Plan:
- Reset, then PC_I=0x100 -> Hit=0, Predict=0, Prediction=0; repeat for 4 random PCs.
- Taken branch update PC=0x100, target=0x80 -> next cycle PC_I=0x100 gives Hit=1, Predict=1, Prediction=0x80 (ctr=10).
- Three not-taken updates at 0x100 -> ctr 10→01→00→00; Predict=0 after the first, Hit stays 1. Two taken updates -> ctr 01, then 10 with Predict=1.
- Jump update PC=0x200, target=0x1001 -> Prediction=0x1000, Predict=1. Then 5 not-taken-style updates with IsJump=1 -> Predict stays 1.
- Alias (ENTRIES=16): taken at 0x100, then taken at 0x140 (same index) -> lookup 0x100 misses, 0x140 hits. Not-taken at 0x180 -> 0x140 still hits.
- Same-cycle update and lookup of 0x300 on a miss -> Hit=0 that cycle, Hit=1 next cycle. FlushAll with a simultaneous update -> all lookups miss afterward.
